// File: rtl/imm_pkg.sv
// imm_pkg: shared mode/state types and default sizes for the immediate assembler
package imm_pkg;
  localparam int CHUNK_W_DEF = 16;
  localparam int NCHUNK_DEF = 2;
  typedef enum logic [1:0] {IMM_ZERO, IMM_MERGE, IMM_SEXT, IMM_RSVD} mode_t;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/imm_place.sv
// imm_place: combinational placement of one immediate beat into a chunk slot
module imm_place
  import imm_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int NCHUNK = NCHUNK_DEF,
  parameter int SEL_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
  parameter int DATA_W = CHUNK_W * NCHUNK
) (
  input  logic [DATA_W-1:0]  acc_i,
  input  logic [CHUNK_W-1:0] imm_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  mode_t              mode_i,
  output logic [DATA_W-1:0]  nxt_o,
  output logic               legal_o
);
  assign legal_o = (mode_i != IMM_RSVD) && (32'(sel_i) < NCHUNK);
  for (genvar g = 0; g < NCHUNK; g++) begin : g_slot
    assign nxt_o[g*CHUNK_W +: CHUNK_W] =
      (32'(sel_i) == g) ? imm_i :
      (mode_i == IMM_SEXT && 32'(sel_i) < g) ? {CHUNK_W{imm_i[CHUNK_W-1]}} :
      (mode_i == IMM_MERGE) ? acc_i[g*CHUNK_W +: CHUNK_W] : '0;
  end
endmodule

// File: rtl/imm_assembler.sv
// imm_assembler: multi-beat load-immediate builder with ready/valid on both sides
module imm_assembler
  import imm_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int NCHUNK = NCHUNK_DEF,
  localparam int DATA_W = CHUNK_W * NCHUNK,
  localparam int SEL_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [CHUNK_W-1:0] imm_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [1:0]         mode_i,
  input  logic               last_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  out_data_o,
  output logic               err_o
);
  logic [DATA_W-1:0] acc_q, acc_d, data_q, data_d, nxt, acc_eff;
  logic valid_q, valid_d, err_q, err_d, legal, take, fire;
  state_t state_q, state_d, ret_q, ret_d, base;
  assign in_ready_o = !valid_q || out_ready_i;
  assign take = in_valid_i && in_ready_o;
  assign fire = take && legal;
  assign base = (state_q == HOLD) ? ret_q : state_q;
  // Only an open constant contributes to MERGE; an idle accumulator reads as zero.
  assign acc_eff = (base == ACCUM) ? acc_q : '0;
  imm_place #(.CHUNK_W(CHUNK_W), .NCHUNK(NCHUNK), .SEL_W(SEL_W)) u_place (
    .acc_i(acc_eff),
    .imm_i(imm_i),
    .sel_i(sel_i),
    .mode_i(mode_t'(mode_i)),
    .nxt_o(nxt),
    .legal_o(legal)
  );
  always_comb begin
    err_d = take && !legal;
    acc_d = !fire ? acc_q : last_i ? '0 : nxt;
    data_d = (fire && last_i) ? nxt : data_q;
    valid_d = (fire && last_i) || (valid_q && !out_ready_i);
    ret_d = !fire ? base : last_i ? IDLE : ACCUM;
    state_d = (valid_q && !out_ready_i) ? HOLD : ret_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      state_q <= IDLE;
      ret_q <= IDLE;
    end else begin
      acc_q <= acc_d;
      data_q <= data_d;
      valid_q <= valid_d;
      err_q <= err_d;
      state_q <= state_d;
      ret_q <= ret_d;
    end
  end
  assign out_valid_o = valid_q;
  assign out_data_o = data_q;
  assign err_o = err_q;
endmodule

// File: doc/imm_assembler.md
# imm_assembler

Parametrised load-immediate assembler: builds a DATA_W-wide constant from one or more CHUNK_W-bit immediate beats, each placed into a selected chunk slot with zero-fill, merge or sign-extend semantics. It sits between the instruction decode stage and the register-file write port. It replaces the fixed 16→32 high/low placement with multi-beat accumulation and a ready/valid handshake on both sides.

## Interface
- CHUNK_W, 16, immediate beat width
- NCHUNK, 2, chunk slots per result; DATA_W = CHUNK_W*NCHUNK; SEL_W = max(1,$clog2(NCHUNK))

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- imm  in  CHUNK_W  immediate chunk
- sel  in  SEL_W  target slot (0 = least significant)
- mode  in  2  00 ZERO, 01 MERGE, 10 SEXT, 11 reserved
- last  in  1  final beat of this constant
- out_valid  out  1  assembled constant available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  DATA_W  assembled constant
- err  out  1  one-cycle pulse on an accepted illegal beat

## Operation
- Internal accumulator acc[DATA_W]; output register out_data/out_valid.
- For an accepted beat, candidate value nxt:
  - ZERO: slot sel = imm, all other slots 0.
  - MERGE: acc with slot sel replaced by imm.
  - SEXT: slot sel = imm; slots above sel = all copies of imm[CHUNK_W-1]; slots below = 0.
  - mode 11 or sel >= NCHUNK: beat is illegal. err pulses, acc is unchanged, and a last flag on the beat is ignored; the constant stays open.
- Legal beat with last=0: acc <= nxt.
- Legal beat with last=1: out_data <= nxt, out_valid <= 1, acc <= 0.
- acc is 0 at the start of every constant, so a MERGE first beat equals ZERO.
- in_ready = !out_valid || out_ready. A held result stalls all input beats, including non-last beats.
- States:
  - IDLE: acc == 0, no beat accepted since the last completion.
  - ACCUM: at least one non-last legal beat accepted.
  - HOLD: out_valid=1 && !out_ready.
- Transitions:
  - IDLE/ACCUM → ACCUM on a non-last legal beat.
  - IDLE/ACCUM → IDLE (out_valid=1) on a last legal beat.
  - out_valid with !out_ready → HOLD.
  - HOLD → previous state on out_ready.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, err=0, acc=0, state IDLE.
- Latency: out_valid rises on the clock edge that accepts the last beat, so data is visible in the following cycle.
- Throughput: one beat per cycle. Back-to-back single-beat constants are sustained while out_ready=1.
- Simultaneous out handshake and a new last beat in the same cycle: out_data is replaced by the new constant and out_valid stays 1 with no bubble.
- out_data and out_valid are stable while out_valid && !out_ready.
- err is registered and asserts in the cycle after the illegal beat; it is never asserted on a non-accepted beat.
- Reset asserted mid-constant clears acc and out_valid immediately (asynchronous); the partial constant is lost.

## Structure
- Package imm_pkg:
  - mode_t enum {IMM_ZERO, IMM_MERGE, IMM_SEXT, IMM_RSVD}
  - state enum {IDLE, ACCUM, HOLD}
  - default CHUNK_W/NCHUNK localparams
- One sub-module, imm_place: purely combinational computation of nxt from (acc, imm, sel, mode), with a legal flag output.
- The top module holds acc, the output register, the FSM and the handshake.

## Test plan
- Single-beat ZERO: imm=16'hABCD, sel=1, last=1 → out_data=32'hABCD_0000 one cycle later; sel=0 → 32'h0000_ABCD.
- Two-beat MERGE: beat 1 ZERO imm=16'h1234 sel=1 last=0, then beat 2 MERGE imm=16'h5678 sel=0 last=1 → 32'h1234_5678, and acc is 0 afterwards.
- SEXT: imm=16'h8001 sel=0 last=1 → 32'hFFFF_8001; imm=16'h7001 → 32'h0000_7001.
- Backpressure: out_ready=0 for 3 cycles after a result → in_ready=0 and out_data held; a queued beat is accepted in the cycle out_ready=1, with no beat lost or duplicated.
- Illegal beat: mode=11 last=1 → err pulse, no out_valid, acc unchanged; with NCHUNK=3, sel=3 → err.
- Reset mid-constant: rst_n low after a non-last beat → out_valid=0; a next single-beat MERGE imm=16'h00FF sel=0 → 48'h0000_0000_00FF.
